axi_store_buffer: RTL and testbench

- Sits directly upstream of the AXI network's master request port, between the CPU load/store unit and the network.
- Posts CPU stores into a small in-order queue and drains them one at a time through the network's write start/done handshake.
- Issues CPU loads through the read start/done handshake. A load whose word address matches a pending store stalls until that store has completed.
- Sticky error reporting for posted stores, which the CPU cannot observe synchronously.

---
 rtl/axi_interface_pkg.sv | 38 +++
 rtl/store_buffer_queue.sv | 76 +++++++
 rtl/axi_store_buffer.sv | 176 +++++++++++++++++
 tb/tb_axi_store_buffer.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_interface_pkg.sv
// Shared types for the AXI master-side store buffer.
// Response codes, queue entry layout and FSM state encodings.
package axi_interface_pkg;

    typedef enum logic [1:0] {
        OKAY   = 2'b00,
        EXOKAY = 2'b01,
        SLVERR = 2'b10,
        DECERR = 2'b11
    } axi_response_t;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] data;
        logic [3:0]  strobe;
    } store_entry_t;

    typedef enum logic [1:0] {
        D_IDLE,
        D_ISSUE,
        D_WAIT
    } drain_state_t;

    typedef enum logic [1:0] {
        L_IDLE,
        L_CHECK,
        L_ISSUE,
        L_WAIT
    } load_state_t;

    function automatic logic word_match(
        input logic [31:0] a,
        input logic [31:0] b
    );
        return a[31:2] == b[31:2];
    endfunction

endpackage

// File: rtl/store_buffer_queue.sv
// Circular store queue with per-entry word-address hazard compare.
// The head entry stays valid until it is explicitly popped.
module store_buffer_queue
    import axi_interface_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  store_entry_t push_entry,
    input  logic         pop,
    output store_entry_t head,
    output logic         full,
    output logic         empty,
    input  logic [31:0]  check_address,
    output logic         hazard
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
    localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] PTR_ONE  = PW'(1);

    store_entry_t     mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;

    assign full  = (count == CNT_FULL);
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Pointer, occupancy and per-entry valid bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            valid  <= '0;
        end else begin
            if (push) begin
                wr_ptr        <= wr_ptr + PTR_ONE;
                valid[wr_ptr] <= 1'b1;
            end
            if (pop) begin
                rd_ptr        <= rd_ptr + PTR_ONE;
                valid[rd_ptr] <= 1'b0;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Entry payload storage; contents are qualified by valid.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

    // Any valid entry in the same 32-bit word as the checked address.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid[i] && word_match(mem[i].address, check_address)) begin
                hazard = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_store_buffer.sv
// Posted-write store buffer in front of the AXI master request port.
// Stores drain in order; loads wait only on same-word pending stores.
module axi_store_buffer
    import axi_interface_pkg::*;
#(
    parameter int BUFFER_DEPTH = 4
) (
    input  logic          axi_ACLK,
    input  logic          axi_ARESETN,
    input  logic          store_valid_i,
    input  logic [31:0]   store_address_i,
    input  logic [31:0]   store_data_i,
    input  logic [3:0]    store_strobe_i,
    output logic          store_ready_o,
    input  logic          load_valid_i,
    input  logic [31:0]   load_address_i,
    output logic          load_ready_o,
    output logic [31:0]   load_data_o,
    output logic          load_done_o,
    output logic          load_error_o,
    output logic          buffer_empty_o,
    output logic          store_error_o,
    output logic [31:0]   store_error_address_o,
    input  logic          clear_error_i,
    output logic          write_start_o,
    output logic [31:0]   write_address_o,
    output logic [31:0]   write_data_o,
    output logic [3:0]    write_strobe_o,
    input  logic          write_done_i,
    input  logic          write_cts_i,
    input  axi_response_t write_response_i,
    output logic          read_start_o,
    output logic [31:0]   read_address_o,
    input  logic [31:0]   read_data_i,
    input  logic          read_done_i,
    input  logic          read_cts_i,
    input  axi_response_t read_response_i
);

    drain_state_t drain_state;
    load_state_t  load_state;
    store_entry_t push_entry;
    store_entry_t head;
    store_entry_t issue_entry;
    logic         full;
    logic         empty;
    logic         push;
    logic         pop;
    logic         q_hazard;
    logic         hazard;
    logic [31:0]  load_addr_q;

    assign push_entry = '{
        address: store_address_i,
        data:    store_data_i,
        strobe:  store_strobe_i
    };

    assign store_ready_o  = !full;
    assign push           = store_valid_i & store_ready_o;
    assign pop            = (drain_state == D_WAIT) & write_done_i;
    assign buffer_empty_o = empty & (drain_state == D_IDLE);
    assign load_ready_o   = (load_state == L_IDLE) & load_valid_i;

    // An empty queue forwards the incoming store so it can issue next cycle.
    assign issue_entry = empty ? push_entry : head;

    // A store entering this cycle is a hazard before it lands in the queue.
    assign hazard = q_hazard
                  | (push & word_match(store_address_i, load_addr_q));

    store_buffer_queue #(
        .DEPTH(BUFFER_DEPTH)
    ) u_queue (
        .clk          (axi_ACLK),
        .rst_n        (axi_ARESETN),
        .push         (push),
        .push_entry   (push_entry),
        .pop          (pop),
        .head         (head),
        .full         (full),
        .empty        (empty),
        .check_address(load_addr_q),
        .hazard       (q_hazard)
    );

    // Drain FSM: one write in flight, plus sticky first-error capture.
    always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
        if (!axi_ARESETN) begin
            drain_state           <= D_IDLE;
            write_start_o         <= 1'b0;
            write_address_o       <= '0;
            write_data_o          <= '0;
            write_strobe_o        <= '0;
            store_error_o         <= 1'b0;
            store_error_address_o <= '0;
        end else begin
            write_start_o <= 1'b0;
            unique case (drain_state)
                D_IDLE: begin
                    if ((!empty | push) & write_cts_i) begin
                        drain_state     <= D_ISSUE;
                        write_start_o   <= 1'b1;
                        write_address_o <= issue_entry.address;
                        write_data_o    <= issue_entry.data;
                        write_strobe_o  <= issue_entry.strobe;
                    end
                end
                D_ISSUE: begin
                    drain_state <= D_WAIT;
                end
                D_WAIT: begin
                    if (write_done_i) begin
                        drain_state <= D_IDLE;
                    end
                end
                default: begin
                    drain_state <= D_IDLE;
                end
            endcase
            if (pop && (write_response_i != OKAY) && !store_error_o) begin
                store_error_o         <= 1'b1;
                store_error_address_o <= write_address_o;
            end else if (clear_error_i) begin
                store_error_o <= 1'b0;
            end
        end
    end

    // Load FSM: accept, wait out same-word stores, read, return result.
    always_ff @(posedge axi_ACLK or negedge axi_ARESETN) begin
        if (!axi_ARESETN) begin
            load_state     <= L_IDLE;
            load_addr_q    <= '0;
            read_start_o   <= 1'b0;
            read_address_o <= '0;
            load_data_o    <= '0;
            load_done_o    <= 1'b0;
            load_error_o   <= 1'b0;
        end else begin
            read_start_o <= 1'b0;
            load_done_o  <= 1'b0;
            load_error_o <= 1'b0;
            unique case (load_state)
                L_IDLE: begin
                    if (load_valid_i) begin
                        load_addr_q <= load_address_i;
                        load_state  <= L_CHECK;
                    end
                end
                L_CHECK: begin
                    if (!hazard && read_cts_i) begin
                        load_state     <= L_ISSUE;
                        read_start_o   <= 1'b1;
                        read_address_o <= load_addr_q;
                    end
                end
                L_ISSUE: begin
                    load_state <= L_WAIT;
                end
                L_WAIT: begin
                    if (read_done_i) begin
                        load_state   <= L_IDLE;
                        load_data_o  <= read_data_i;
                        load_done_o  <= 1'b1;
                        load_error_o <= (read_response_i != OKAY);
                    end
                end
                default: begin
                    load_state <= L_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_axi_store_buffer.sv
// Directed self-checking bench for axi_store_buffer.
// Inputs change 1ns after the rising edge; outputs are sampled there too.
module tb_axi_store_buffer;
    import axi_interface_pkg::*;

    logic          clk;
    logic          rst_n;
    logic          store_valid;
    logic [31:0]   store_address;
    logic [31:0]   store_data;
    logic [3:0]    store_strobe;
    logic          store_ready_o;
    logic          load_valid;
    logic [31:0]   load_address;
    logic          load_ready_o;
    logic [31:0]   load_data_o;
    logic          load_done_o;
    logic          load_error_o;
    logic          buffer_empty_o;
    logic          store_error_o;
    logic [31:0]   store_error_address_o;
    logic          clear_error;
    logic          write_start_o;
    logic [31:0]   write_address_o;
    logic [31:0]   write_data_o;
    logic [3:0]    write_strobe_o;
    logic          write_done;
    logic          write_cts;
    axi_response_t write_response;
    logic          read_start_o;
    logic [31:0]   read_address_o;
    logic [31:0]   read_data;
    logic          read_done;
    logic          read_cts;
    axi_response_t read_response;

    int checks   = 0;
    int failures = 0;
    logic seen;
    logic [31:0] exp_addr [5];

    axi_store_buffer #(.BUFFER_DEPTH(4)) dut (
        .axi_ACLK             (clk),
        .axi_ARESETN          (rst_n),
        .store_valid_i        (store_valid),
        .store_address_i      (store_address),
        .store_data_i         (store_data),
        .store_strobe_i       (store_strobe),
        .store_ready_o        (store_ready_o),
        .load_valid_i         (load_valid),
        .load_address_i       (load_address),
        .load_ready_o         (load_ready_o),
        .load_data_o          (load_data_o),
        .load_done_o          (load_done_o),
        .load_error_o         (load_error_o),
        .buffer_empty_o       (buffer_empty_o),
        .store_error_o        (store_error_o),
        .store_error_address_o(store_error_address_o),
        .clear_error_i        (clear_error),
        .write_start_o        (write_start_o),
        .write_address_o      (write_address_o),
        .write_data_o         (write_data_o),
        .write_strobe_o       (write_strobe_o),
        .write_done_i         (write_done),
        .write_cts_i          (write_cts),
        .write_response_i     (write_response),
        .read_start_o         (read_start_o),
        .read_address_o       (read_address_o),
        .read_data_i          (read_data),
        .read_done_i          (read_done),
        .read_cts_i           (read_cts),
        .read_response_i      (read_response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_wstart(input string tag);
        int n = 0;
        while (!write_start_o && n < 20) begin
            step();
            n++;
        end
        chk1(tag, write_start_o, 1'b1);
    endtask

    task automatic wait_rstart(input string tag);
        int n = 0;
        while (!read_start_o && n < 20) begin
            step();
            n++;
        end
        chk1(tag, read_start_o, 1'b1);
    endtask

    task automatic put_store(input logic [31:0] a, input logic [31:0] d);
        store_valid   = 1'b1;
        store_address = a;
        store_data    = d;
        store_strobe  = 4'hF;
    endtask

    initial begin
        rst_n          = 1'b0;
        store_valid    = 1'b0;
        store_address  = '0;
        store_data     = '0;
        store_strobe   = '0;
        load_valid     = 1'b0;
        load_address   = '0;
        clear_error    = 1'b0;
        write_done     = 1'b0;
        write_cts      = 1'b0;
        write_response = OKAY;
        read_data      = '0;
        read_done      = 1'b0;
        read_cts       = 1'b0;
        read_response  = OKAY;
        exp_addr       = '{32'h100, 32'h104, 32'h108, 32'h10C, 32'h110};

        // reset values
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_store_ready", store_ready_o, 1'b1);
        chk1("rst_buffer_empty", buffer_empty_o, 1'b1);
        chk1("rst_write_start", write_start_o, 1'b0);
        chk1("rst_read_start", read_start_o, 1'b0);
        chk1("rst_load_done", load_done_o, 1'b0);
        chk1("rst_store_error", store_error_o, 1'b0);
        chk32("rst_write_addr", write_address_o, 32'h0);
        rst_n = 1'b1;
        step();

        // single store, issue one cycle after push
        write_cts = 1'b1;
        put_store(32'h1000_0004, 32'hDEAD_BEEF);
        chk1("single_ready", store_ready_o, 1'b1);
        step();
        store_valid = 1'b0;
        chk1("single_wstart", write_start_o, 1'b1);
        chk32("single_waddr", write_address_o, 32'h1000_0004);
        chk32("single_wdata", write_data_o, 32'hDEAD_BEEF);
        chk32("single_wstrb", {28'h0, write_strobe_o}, 32'hF);
        chk1("single_not_empty", buffer_empty_o, 1'b0);
        step();
        chk1("single_wstart_pulse", write_start_o, 1'b0);
        chk1("single_wait_not_empty", buffer_empty_o, 1'b0);
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        chk1("single_empty_after_done", buffer_empty_o, 1'b1);

        // fill the queue with cts low, fifth store held
        write_cts = 1'b0;
        for (int i = 0; i < 4; i++) begin
            put_store(exp_addr[i], 32'hA000_0000 + 32'(i));
            step();
        end
        put_store(exp_addr[4], 32'hA000_0004);
        chk1("full_ready", store_ready_o, 1'b0);
        step();
        chk1("full_held", store_ready_o, 1'b0);
        chk1("full_no_wstart", write_start_o, 1'b0);
        write_cts = 1'b1;
        step();
        for (int k = 0; k < 5; k++) begin
            wait_wstart("fill_wstart");
            chk32("fill_order", write_address_o, exp_addr[k]);
            step();
            write_done = 1'b1;
            step();
            write_done = 1'b0;
            if (k == 0) begin
                chk1("fill_slot_freed", store_ready_o, 1'b1);
                step();
                store_valid = 1'b0;
            end
        end
        chk1("fill_drained", buffer_empty_o, 1'b1);

        // RAW hazard: load 0x2002 waits on pending store to 0x2000
        read_cts = 1'b1;
        put_store(32'h2000, 32'h11);
        step();
        store_valid = 1'b0;
        chk1("raw_store_wstart", write_start_o, 1'b1);
        step();
        load_valid   = 1'b1;
        load_address = 32'h2002;
        chk1("raw_load_ready", load_ready_o, 1'b1);
        step();
        load_valid = 1'b0;
        seen = 1'b0;
        repeat (5) begin
            if (read_start_o) seen = 1'b1;
            step();
        end
        chk1("raw_stall", seen, 1'b0);
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        wait_rstart("raw_rstart");
        chk32("raw_raddr", read_address_o, 32'h2002);
        step();
        read_done = 1'b1;
        read_data = 32'hCAFE_0001;
        step();
        read_done = 1'b0;
        chk1("raw_load_done", load_done_o, 1'b1);
        chk32("raw_load_data", load_data_o, 32'hCAFE_0001);
        chk1("raw_load_error", load_error_o, 1'b0);

        // control: different word issues without waiting, 4-cycle latency
        put_store(32'h2000, 32'h22);
        step();
        store_valid = 1'b0;
        chk1("ctl_store_wstart", write_start_o, 1'b1);
        step();
        load_valid   = 1'b1;
        load_address = 32'h2004;
        step();
        load_valid = 1'b0;
        step();
        chk1("ctl_rstart", read_start_o, 1'b1);
        chk32("ctl_raddr", read_address_o, 32'h2004);
        step();
        read_done = 1'b1;
        read_data = 32'h1234_5678;
        step();
        read_done = 1'b0;
        chk1("ctl_load_done", load_done_o, 1'b1);
        chk32("ctl_load_data", load_data_o, 32'h1234_5678);
        chk1("ctl_store_pending", buffer_empty_o, 1'b0);
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        chk1("ctl_empty", buffer_empty_o, 1'b1);

        // sticky store errors
        put_store(32'h3000, 32'h0);
        step();
        store_valid = 1'b0;
        step();
        write_done     = 1'b1;
        write_response = SLVERR;
        step();
        write_done     = 1'b0;
        write_response = OKAY;
        chk1("err_set", store_error_o, 1'b1);
        chk32("err_addr", store_error_address_o, 32'h3000);
        put_store(32'h3004, 32'h0);
        step();
        store_valid = 1'b0;
        step();
        write_done     = 1'b1;
        write_response = SLVERR;
        step();
        write_done     = 1'b0;
        write_response = OKAY;
        chk1("err_still_set", store_error_o, 1'b1);
        chk32("err_addr_kept", store_error_address_o, 32'h3000);
        clear_error = 1'b1;
        step();
        clear_error = 1'b0;
        chk1("err_cleared", store_error_o, 1'b0);
        put_store(32'h3008, 32'h0);
        step();
        store_valid = 1'b0;
        step();
        write_done     = 1'b1;
        write_response = SLVERR;
        clear_error    = 1'b1;
        step();
        write_done     = 1'b0;
        write_response = OKAY;
        clear_error    = 1'b0;
        chk1("err_capture_wins", store_error_o, 1'b1);
        chk32("err_capture_addr", store_error_address_o, 32'h3008);
        clear_error = 1'b1;
        step();
        clear_error = 1'b0;

        // load with DECERR
        load_valid   = 1'b1;
        load_address = 32'h4000;
        step();
        load_valid = 1'b0;
        step();
        step();
        read_done     = 1'b1;
        read_data     = 32'h0;
        read_response = DECERR;
        step();
        read_done     = 1'b0;
        read_response = OKAY;
        chk1("decerr_done", load_done_o, 1'b1);
        chk1("decerr_error", load_error_o, 1'b1);
        chk32("decerr_data", load_data_o, 32'h0);
        step();
        chk1("decerr_pulse", load_done_o, 1'b0);

        // reset while in WAIT with three stores queued
        write_cts = 1'b0;
        put_store(32'h500, 32'h5);
        step();
        put_store(32'h504, 32'h6);
        step();
        put_store(32'h508, 32'h7);
        step();
        store_valid = 1'b0;
        write_cts   = 1'b1;
        step();
        step();
        chk1("mid_not_empty", buffer_empty_o, 1'b0);
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_ready", store_ready_o, 1'b1);
        chk1("mid_rst_empty", buffer_empty_o, 1'b1);
        chk1("mid_rst_wstart", write_start_o, 1'b0);
        chk32("mid_rst_waddr", write_address_o, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen  = 1'b0;
        repeat (5) begin
            step();
            if (write_start_o) seen = 1'b1;
        end
        chk1("mid_no_wstart", seen, 1'b0);
        put_store(32'h600, 32'h66);
        step();
        store_valid = 1'b0;
        chk1("mid_new_wstart", write_start_o, 1'b1);
        chk32("mid_new_waddr", write_address_o, 32'h600);
        step();
        write_done = 1'b1;
        step();
        write_done = 1'b0;
        chk1("mid_final_empty", buffer_empty_o, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
